// File: rtl/axis_rgb_packer.sv
// Packs an R,G,B byte stream into 32-bit {0,B,G,R} pixel words and checks s_tlast against the frame length.
// Define AXIS_RGB_PACKER_RESYNC_EN to realign phase and pixel count on a framing mismatch.
module axis_rgb_packer #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned FRAME_PIX = H_VISIBLE * V_VISIBLE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        frame_err,
    output logic [15:0] err_cnt
);
    localparam int unsigned PIX_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    phase_e             ph_q, ph_d;
    logic [7:0]         r_q, r_d, g_q, g_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               rdy_q;
    logic               err_q, err_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    // Two-entry output FIFO; each entry holds {tlast, B, G, R}.
    logic [24:0]        mem_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         cnt_q, cnt_d;

    logic               accept, wr_en, rd_en, wr_last;
    logic [24:0]        wr_word;

    assign m_tvalid  = (cnt_q != 2'd0);
    assign m_tdata   = {8'h00, mem_q[rd_ptr_q][23:0]};
    assign m_tlast   = m_tvalid & mem_q[rd_ptr_q][24];
    assign s_tready  = rdy_q & ((ph_q != PH_B) | (cnt_q != 2'd2));
    assign frame_err = err_q;
    assign err_cnt   = err_cnt_q;

    assign accept = s_tvalid & s_tready;
    assign rd_en  = m_tvalid & m_tready;

    always_comb begin
        ph_d    = ph_q;
        r_d     = r_q;
        g_d     = g_q;
        pix_d   = pix_q;
        wr_en   = 1'b0;
        wr_last = (pix_q == PIX_LAST);
        err_d   = 1'b0;
        if (accept) begin
            case (ph_q)
                PH_R: begin
                    r_d  = s_tdata;
                    ph_d = PH_G;
                end
                PH_G: begin
                    g_d  = s_tdata;
                    ph_d = PH_B;
                end
                default: begin
                    wr_en = 1'b1;
                    ph_d  = PH_R;
                    pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1);
                end
            endcase
            if (ph_q != PH_B) begin
                if (s_tlast) begin
                    err_d = 1'b1;
`ifdef AXIS_RGB_PACKER_RESYNC_EN
                    ph_d  = PH_R;
                    pix_d = '0;
`endif
                end
            end else if (s_tlast != (pix_q == PIX_LAST)) begin
                err_d = 1'b1;
`ifdef AXIS_RGB_PACKER_RESYNC_EN
                // Early end: close the frame here; a late end already carries tlast.
                if (s_tlast) begin
                    wr_last = 1'b1;
                    pix_d   = '0;
                end
`endif
            end
        end
        wr_word   = {wr_last, s_tdata, g_q, r_q};
        cnt_d     = cnt_q + {1'b0, wr_en} - {1'b0, rd_en};
        err_cnt_d = (err_d && (err_cnt_q != '1)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ph_q      <= PH_R;
            r_q       <= '0;
            g_q       <= '0;
            pix_q     <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ph_q      <= ph_d;
            r_q       <= r_d;
            g_q       <= g_d;
            pix_q     <= pix_d;
            rdy_q     <= 1'b1;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_q ^ wr_en;
            rd_ptr_q  <= rd_ptr_q ^ rd_en;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_word;
            end
        end
    end
endmodule

// File: tb/tb_axis_rgb_packer.sv
// Directed bench for axis_rgb_packer with an 4x2 frame (8 pixels, 24 bytes).
module tb_axis_rgb_packer;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        frame_err;
    logic [15:0] err_cnt;

    axis_rgb_packer #(.H_VISIBLE(4), .V_VISIBLE(2)) dut (
        .clk(clk), .rstn(rstn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r, g, b;
        logic        last_b;
        logic [31:0] exp_word;
        logic        exp_last;
    } pix_vec_t;

    pix_vec_t    tv [8];
    int          checks = 0;
    int          errors = 0;
    logic [32:0] got_q [$];
    logic [32:0] exp_q [$];
    int          acc_cnt = 0;
    int          stall_cnt = 0;
    int          err_pulses = 0;
    int          unstable = 0;

    // Handshakes complete at the next posedge; inputs only change #1 after posedge.
    always @(negedge clk) begin
        if (rstn && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
        if (rstn && s_tvalid && s_tready) acc_cnt++;
        if (rstn && s_tvalid && !s_tready) stall_cnt++;
        if (frame_err) err_pulses++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int unsigned waited = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_byte_timeout: byte %0h not accepted after %0d cycles", d, waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input bit chk, input bit drop_last);
        for (int i = 0; i < 8; i++) begin
            send_byte(tv[i].r, 1'b0);
            send_byte(tv[i].g, 1'b0);
            send_byte(tv[i].b, tv[i].last_b && !drop_last);
            if (chk) begin
                check("word_valid", {63'd0, m_tvalid}, 64'd1);
                check("word_data", {32'd0, m_tdata}, {32'd0, tv[i].exp_word});
                check("word_last", {63'd0, m_tlast}, {63'd0, tv[i].exp_last});
                check("no_frame_err", {63'd0, frame_err}, 64'd0);
            end
        end
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic compare_words(input string name, input int start);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_count"}, 64'(got_q.size() - start), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (start + i < got_q.size())
                check({name, "_word"}, {31'd0, got_q[start + i]}, {31'd0, exp_q[i]});
        end
    endtask

    task automatic expect_table(input int from, input int to);
        for (int i = from; i <= to; i++) exp_q.push_back({tv[i].exp_last, tv[i].exp_word});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, a0, s0, e0;
        tv[0] = '{8'h01, 8'h02, 8'h03, 1'b0, 32'h0003_0201, 1'b0};
        tv[1] = '{8'h04, 8'h05, 8'h06, 1'b0, 32'h0006_0504, 1'b0};
        tv[2] = '{8'h07, 8'h08, 8'h09, 1'b0, 32'h0009_0807, 1'b0};
        tv[3] = '{8'h0A, 8'h0B, 8'h0C, 1'b0, 32'h000C_0B0A, 1'b0};
        tv[4] = '{8'h0D, 8'h0E, 8'h0F, 1'b0, 32'h000F_0E0D, 1'b0};
        tv[5] = '{8'h10, 8'h11, 8'h12, 1'b0, 32'h0012_1110, 1'b0};
        tv[6] = '{8'h13, 8'h14, 8'h15, 1'b0, 32'h0015_1413, 1'b0};
        tv[7] = '{8'h16, 8'h17, 8'h18, 1'b1, 32'h0018_1716, 1'b1};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", {63'd0, s_tready}, 64'd0);
        check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
        check("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_s_tready", {63'd0, s_tready}, 64'd1);

        // Clean frame with m_tready high
        start = got_q.size(); s0 = stall_cnt; e0 = err_pulses;
        send_frame(1'b1, 1'b0);
        exp_q.delete(); expect_table(0, 7);
        compare_words("clean", start);
        check("clean_stalls", 64'(stall_cnt - s0), 64'd0);
        check("clean_err_pulses", 64'(err_pulses - e0), 64'd0);

        // Backpressure: output blocked for 20 cycles from frame start
        start = got_q.size(); a0 = acc_cnt; unstable = 0;
        m_tready = 1'b0;
        fork
            send_frame(1'b0, 1'b0);
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (m_tvalid && (m_tdata !== 32'h0003_0201 || m_tlast !== 1'b0)) unstable++;
                end
                check("bp_accepted", 64'(acc_cnt - a0), 64'd8);
                check("bp_s_tready", {63'd0, s_tready}, 64'd0);
                check("bp_m_tvalid", {63'd0, m_tvalid}, 64'd1);
                check("bp_unstable", 64'(unstable), 64'd0);
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        exp_q.delete(); expect_table(0, 7);
        compare_words("bp", start);

        // Early s_tlast on byte 7 (R of third pixel)
        do_reset();
        start = got_q.size(); e0 = err_pulses;
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b1);
        check("early_frame_err", {63'd0, frame_err}, 64'd1);
        check("early_err_cnt", {48'd0, err_cnt}, 64'd1);
        exp_q.delete();
`ifdef AXIS_RGB_PACKER_RESYNC_EN
        send_frame(1'b0, 1'b0);
        expect_table(0, 1);
        expect_table(0, 7);
`else
        send_byte(8'h08, 1'b0);
        check("early_pulse_end", {63'd0, frame_err}, 64'd0);
        send_byte(8'h09, 1'b0);
        for (int i = 3; i < 8; i++) begin
            send_byte(tv[i].r, 1'b0);
            send_byte(tv[i].g, 1'b0);
            send_byte(tv[i].b, tv[i].last_b);
        end
        expect_table(0, 7);
`endif
        compare_words("early", start);
        check("early_err_total", {48'd0, err_cnt}, 64'd1);
        check("early_pulses", 64'(err_pulses - e0), 64'd1);

        // Missing s_tlast on byte 24
        do_reset();
        send_frame(1'b0, 1'b1);
        check("miss_m_tlast", {63'd0, m_tlast}, 64'd1);
        check("miss_m_tdata", {32'd0, m_tdata}, 64'h0018_1716);
        check("miss_frame_err", {63'd0, frame_err}, 64'd1);
        check("miss_err_cnt", {48'd0, err_cnt}, 64'd1);

        // Reset after byte 10, then a clean frame
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_byte(tv[i].r, 1'b0); send_byte(tv[i].g, 1'b0); send_byte(tv[i].b, 1'b0);
        end
        send_byte(8'h0A, 1'b1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_s_tready", {63'd0, s_tready}, 64'd0);
        check("mid_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("mid_m_tdata", {32'd0, m_tdata}, 64'd0);
        check("mid_m_tlast", {63'd0, m_tlast}, 64'd0);
        check("mid_frame_err", {63'd0, frame_err}, 64'd0);
        check("mid_err_cnt", {48'd0, err_cnt}, 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_s_tready", {63'd0, s_tready}, 64'd1);
        start = got_q.size();
        send_frame(1'b1, 1'b0);
        exp_q.delete(); expect_table(0, 7);
        compare_words("after_rst", start);

        // Error counter saturation
        do_reset();
        s_tdata  = 8'h55;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        #1;
        check("sat_err_cnt", {48'd0, err_cnt}, 64'h0000_0000_0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
